ascon_block_feeder: RTL

ASCON_BLOCK_FEEDER -- requirements
Module: ascon_block_feeder

---
 rtl/ascon_pkg.sv | 45 ++++
 rtl/ascon_block_packer.sv | 24 ++
 rtl/ascon_block_feeder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// Shared Ascon feeder definitions: mode encodings, rate constants, FSM states
// and small byte/word bookkeeping helpers.
package ascon_pkg;

  typedef enum logic [1:0] {
    MODE_AEAD128 = 2'b00,
    MODE_HASH256 = 2'b01,
    MODE_XOF128  = 2'b10,
    MODE_CXOF128 = 2'b11
  } ascon_mode_e;

  localparam int unsigned RATE_AEAD128_BYTES = 16;
  localparam int unsigned RATE_HASH_BYTES    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01,
    ST_HOLD = 2'b10,
    ST_DONE = 2'b11
  } feeder_state_e;

  // Bytes carried by the block starting at pos: min(rate, len - pos).
  function automatic logic [4:0] block_bytes(input logic [31:0] len,
                                             input logic [31:0] pos,
                                             input logic [4:0]  rate);
    logic [31:0] rem;
    rem = len - pos;
    if (rem < {27'd0, rate}) begin
      block_bytes = rem[4:0];
    end else begin
      block_bytes = rate;
    end
  endfunction

  // Input words needed to deliver nbytes: ceil(nbytes / 4).
  function automatic logic [2:0] block_words(input logic [4:0] nbytes);
    block_words = 3'((nbytes + 5'd3) >> 2);
  endfunction

  // Bit offset of block byte k: bytes 0-7 in the upper lane, 8-15 in the lower.
  function automatic logic [6:0] byte_lsb(input logic [3:0] k);
    byte_lsb = {~k[3], k[2:0], 3'b000};
  endfunction

endpackage

// File: rtl/ascon_block_packer.sv
// Combinational placement of one 32-bit input word into the 128-bit block.
// Only the first nbytes_i bytes of the word are written; the rest of the
// block passes through untouched, so a cleared buffer stays zero-padded.
module ascon_block_packer
  import ascon_pkg::*;
(
  input  logic [127:0] blk_i,
  input  logic [1:0]   word_idx_i,
  input  logic [31:0]  word_i,
  input  logic [2:0]   nbytes_i,
  output logic [127:0] blk_o
);

  // Write the valid bytes of the word at their little-endian lane positions
  always_comb begin
    blk_o = blk_i;
    for (int j = 0; j < 4; j++) begin
      blk_o[byte_lsb({word_idx_i, 2'(j)}) +: 8] =
        (3'(j) < nbytes_i) ? word_i[8*j +: 8]
                           : blk_i[byte_lsb({word_idx_i, 2'(j)}) +: 8];
    end
  end

endmodule

// File: rtl/ascon_block_feeder.sv
// Ascon block feeder: gathers a byte stream of 32-bit words into rate-sized
// blocks (16 bytes for AEAD128, 8 for the hash/XOF modes) and hands each one
// downstream with a valid/ack handshake. Always emits floor(len/R)+1 blocks,
// the last one possibly empty.
// Optional build macro ASCON_FEEDER_PINGPONG_EN: adds a separate hold buffer
// so the next block fills while the current one waits for blk_ack.
module ascon_block_feeder
  import ascon_pkg::*;
#(
  parameter int unsigned RATE_AEAD = RATE_AEAD128_BYTES,
  parameter int unsigned RATE_HASH = RATE_HASH_BYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   sel_type,
  input  logic [31:0]  msg_len,
  input  logic [31:0]  s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [127:0] blk_data,
  output logic [31:0]  data_length,
  output logic [31:0]  data_position,
  output logic         blk_valid,
  output logic         blk_last,
  input  logic         blk_ack,
  output logic         busy,
  output logic         done
);

  localparam logic [4:0] RATE_A = 5'(RATE_AEAD);
  localparam logic [4:0] RATE_H = 5'(RATE_HASH);

  feeder_state_e state_q;
  logic          aead_q;
  logic [31:0]   len_q;
  logic [31:0]   pos_q;      // start offset of the presented block
  logic [31:0]   fpos_q;     // start offset of the block being filled
  logic [4:0]    bytes_q;    // bytes in the block being filled
  logic [2:0]    wcnt_q;     // words accepted into the fill buffer
  logic [127:0]  buf_q;
  logic          ffull_q;
  logic          flast_q;
  logic          s_ready_q;
  logic          blk_valid_q;
  logic          blk_last_q;
  logic          busy_q;
  logic          done_q;
`ifdef ASCON_FEEDER_PINGPONG_EN
  logic [127:0]  hold_q;
`endif

  logic [4:0]    rate_s, start_rate_s, left_s, nxt_bytes_s, st_bytes_s;
  logic [2:0]    need_s, nxt_need_s, st_need_s, word_nb_s;
  logic [31:0]   nxt_fpos_s;
  logic          nxt_last_s, st_last_s, beat_s, last_beat_s, fill_cmp_s;
  logic          xfer_s, adv_s, stop_s;
  logic [127:0]  pack_s;

  ascon_block_packer u_packer (
    .blk_i      (buf_q),
    .word_idx_i (wcnt_q[1:0]),
    .word_i     (s_data),
    .nbytes_i   (word_nb_s),
    .blk_o      (pack_s)
  );

  // Fill-side bookkeeping and next-block geometry
  always_comb begin
    rate_s       = aead_q ? RATE_A : RATE_H;
    start_rate_s = (sel_type == MODE_AEAD128) ? RATE_A : RATE_H;
    need_s       = block_words(bytes_q);
    left_s       = bytes_q - {wcnt_q, 2'b00};
    word_nb_s    = (left_s > 5'd4) ? 3'd4 : left_s[2:0];
    beat_s       = s_ready_q && s_valid;
    last_beat_s  = beat_s && ((wcnt_q + 3'd1) == need_s);
    fill_cmp_s   = ffull_q || last_beat_s;
    nxt_fpos_s   = fpos_q + {27'd0, rate_s};
    nxt_bytes_s  = block_bytes(len_q, nxt_fpos_s, rate_s);
    nxt_need_s   = block_words(nxt_bytes_s);
    nxt_last_s   = (len_q - nxt_fpos_s) < {27'd0, rate_s};
    st_bytes_s   = block_bytes(msg_len, 32'd0, start_rate_s);
    st_need_s    = block_words(st_bytes_s);
    st_last_s    = msg_len < {27'd0, start_rate_s};
  end

  // Hand-over and fill-restart decisions
  always_comb begin
`ifdef ASCON_FEEDER_PINGPONG_EN
    // The filled block moves to the hold buffer whenever the hold slot is
    // free or is being released this cycle; the filler then moves on.
    xfer_s = fill_cmp_s && ((state_q == ST_FILL) ||
                            ((state_q == ST_HOLD) && blk_ack && !blk_last_q));
    adv_s  = xfer_s && !flast_q;
    stop_s = xfer_s && flast_q;
`else
    // Single buffer: the filled buffer itself is presented, and filling of
    // the next block only restarts once the current one is acknowledged.
    xfer_s = fill_cmp_s && (state_q == ST_FILL);
    adv_s  = (state_q == ST_HOLD) && blk_ack && !blk_last_q;
    stop_s = 1'b0;
`endif
  end

  // Feeder FSM together with its fill, hold and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      aead_q      <= 1'b0;
      len_q       <= 32'd0;
      pos_q       <= 32'd0;
      fpos_q      <= 32'd0;
      bytes_q     <= 5'd0;
      wcnt_q      <= 3'd0;
      buf_q       <= 128'd0;
      ffull_q     <= 1'b0;
      flast_q     <= 1'b0;
      s_ready_q   <= 1'b0;
      blk_valid_q <= 1'b0;
      blk_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef ASCON_FEEDER_PINGPONG_EN
      hold_q      <= 128'd0;
`endif
    end else begin
      done_q <= 1'b0;
      if (beat_s) begin
        buf_q  <= pack_s;
        wcnt_q <= wcnt_q + 3'd1;
        if (last_beat_s) begin
          s_ready_q <= 1'b0;
          ffull_q   <= 1'b1;
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            aead_q     <= (sel_type == MODE_AEAD128);
            len_q      <= msg_len;
            pos_q      <= 32'd0;
            fpos_q     <= 32'd0;
            flast_q    <= st_last_s;
            blk_last_q <= st_last_s;
            buf_q      <= 128'd0;
            wcnt_q     <= 3'd0;
            bytes_q    <= st_bytes_s;
            ffull_q    <= (st_need_s == 3'd0);
            s_ready_q  <= (st_need_s != 3'd0);
            busy_q     <= 1'b1;
            state_q    <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (xfer_s) begin
            blk_valid_q <= 1'b1;
            blk_last_q  <= flast_q;
            pos_q       <= fpos_q;
            state_q     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (blk_ack) begin
            if (blk_last_q) begin
              blk_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              pos_q <= pos_q + {27'd0, rate_s};
`ifdef ASCON_FEEDER_PINGPONG_EN
              blk_last_q <= flast_q;
              if (!xfer_s) begin
                blk_valid_q <= 1'b0;
                state_q     <= ST_FILL;
              end
`else
              blk_last_q  <= nxt_last_s;
              blk_valid_q <= 1'b0;
              state_q     <= ST_FILL;
`endif
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
`ifdef ASCON_FEEDER_PINGPONG_EN
      if (xfer_s) begin
        hold_q <= ffull_q ? buf_q : pack_s;
      end
`endif
      if (adv_s) begin
        fpos_q    <= nxt_fpos_s;
        flast_q   <= nxt_last_s;
        buf_q     <= 128'd0;
        wcnt_q    <= 3'd0;
        bytes_q   <= nxt_bytes_s;
        ffull_q   <= (nxt_need_s == 3'd0);
        s_ready_q <= (nxt_need_s != 3'd0);
      end else if (stop_s) begin
        ffull_q   <= 1'b0;
        s_ready_q <= 1'b0;
      end
    end
  end

  assign s_ready       = s_ready_q;
`ifdef ASCON_FEEDER_PINGPONG_EN
  assign blk_data      = hold_q;
`else
  assign blk_data      = buf_q;
`endif
  assign data_length   = len_q;
  assign data_position = pos_q;
  assign blk_valid     = blk_valid_q;
  assign blk_last      = blk_last_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
